// File: rtl/display_scan_ctrl.sv
// Scan controller that time-multiplexes one 5-bit segment decoder across up to eight
// common-anode digits. Host writes are double-buffered and committed only at frame boundaries.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [4:0]            wr_data,
  output logic [4:0]            code,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - BLANK - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t             state_q, state_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_done_q, frame_done_d;
  logic [4:0]         shadow_q [NUM_DIGITS];
  logic [4:0]         shadow_d [NUM_DIGITS];
  logic [4:0]         active_q [NUM_DIGITS];
  logic [4:0]         active_d [NUM_DIGITS];
  logic               commit;
  logic [4:0]         cur_code;

  // Out-of-range addresses simply match no entry, so they are dropped.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == 3'(i)) begin
          shadow_d[i] = wr_data;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    commit       = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          digit_d = '0;
          cnt_d   = '0;
          commit  = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (digit_q == DIG_LAST) begin
              digit_d      = '0;
              commit       = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          digit_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // shadow_d already carries a same-edge write, so a colliding write wins the commit.
  always_comb begin
    active_d = active_q;
    if (commit) begin
      active_d = shadow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      digit_q      <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  always_comb begin
    cur_code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        cur_code = active_q[i];
      end
    end
  end

  // Blank slots still present the code so the decoder settles before the anode turns on.
  always_comb begin
    an    = '1;
    code  = '0;
    blank = 1'b1;
    case (state_q)
      ST_BLANK: begin
        code = cur_code;
      end
      ST_SHOW: begin
        code  = cur_code;
        blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          an[i] = (digit_q != DIG_W'(i));
        end
      end
      default: begin
        an    = '1;
        code  = '0;
        blank = 1'b1;
      end
    endcase
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: table-driven scan vectors, hand-written corner sequences,
// and random traffic against a time-indexed reference model.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int DV    = 8;
  localparam int BK    = 2;
  localparam int FRAME = N * DV;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [4:0]   wr_data;
  logic [4:0]   code;
  logic [N-1:0] an;
  logic         blank;
  logic         frame_done;

  int total;
  int bad;

  // Reference model: scan position is elapsed cycles since the first blank cycle.
  bit         m_run;
  int         m_t;
  logic [4:0] m_shadow [4];
  logic [4:0] m_active [4];

  typedef struct {
    logic       e;
    logic       w;
    logic [2:0] a;
    logic [4:0] d;
    int         reps;
    logic [3:0] x_an;
    logic [4:0] x_code;
    logic       x_bl;
    logic       x_fd;
  } vec_t;

  vec_t vecs[$];

  display_scan_ctrl #(.NUM_DIGITS(N), .DIV(DV), .BLANK(BK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .code       (code),
    .an         (an),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 1'b0;
    m_t   = 0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  endtask

  task automatic cycle(input logic e, input logic w, input logic [2:0] a, input logic [4:0] d);
    en      = e;
    wr_en   = w;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    if (w && (int'(a) < N)) m_shadow[a[1:0]] = d;
    if (!e) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run    = 1'b1;
      m_t      = 0;
      m_active = m_shadow;
    end else begin
      m_t = m_t + 1;
      if (m_t % FRAME == 0) m_active = m_shadow;
    end
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] ea, input logic [4:0] ec,
                       input logic eb, input logic ef);
    total++;
    if (an !== ea || code !== ec || blank !== eb || frame_done !== ef) begin
      bad++;
      $display("FAIL %s @%0t: got an=%b code=%0d blank=%b fd=%b, expected an=%b code=%0d blank=%b fd=%b",
               nm, $time, an, code, blank, frame_done, ea, ec, eb, ef);
    end
  endtask

  task automatic check_fd(input string nm, input logic ef);
    total++;
    if (frame_done !== ef) begin
      bad++;
      $display("FAIL %s @%0t: got frame_done=%b, expected %b", nm, $time, frame_done, ef);
    end
  endtask

  task automatic check_model(input string nm);
    logic [3:0] ea;
    logic [4:0] ec;
    logic       eb;
    logic       ef;
    int         dg;
    int         ph;
    if (!m_run) begin
      ea = 4'hF; ec = '0; eb = 1'b1; ef = 1'b0;
    end else begin
      dg = (m_t / DV) % N;
      ph = m_t % DV;
      eb = (ph < BK);
      ec = m_active[dg[1:0]];
      ea = eb ? 4'hF : ~(4'b0001 << dg);
      ef = (m_t > 0) && (m_t % FRAME == 0);
    end
    check(nm, ea, ec, eb, ef);
  endtask

  task automatic add(input logic e, input logic w, input logic [2:0] a, input logic [4:0] d,
                     input int reps, input logic [3:0] xa, input logic [4:0] xc,
                     input logic xb, input logic xf);
    vec_t v;
    v.e = e; v.w = w; v.a = a; v.d = d; v.reps = reps;
    v.x_an = xa; v.x_code = xc; v.x_bl = xb; v.x_fd = xf;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    model_reset();

    // load codes with scan disabled, then one full frame
    add(0, 1, 0, 1, 1, 4'hF, 0, 1, 0);
    add(0, 1, 1, 2, 1, 4'hF, 0, 1, 0);
    add(0, 1, 2, 3, 1, 4'hF, 0, 1, 0);
    add(0, 1, 3, 4, 1, 4'hF, 0, 1, 0);
    add(1, 0, 0, 0, 2, 4'hF, 1, 1, 0);
    add(1, 0, 0, 0, 6, 4'hE, 1, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 2, 1, 0);
    add(1, 0, 0, 0, 6, 4'hD, 2, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 3, 1, 0);
    add(1, 0, 0, 0, 6, 4'hB, 3, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 4, 1, 0);
    add(1, 0, 0, 0, 6, 4'h7, 4, 0, 0);
    // frame 2: write addr1=31 during digit 2 lit time
    add(1, 0, 0, 0, 1, 4'hF, 1, 1, 1);
    add(1, 0, 0, 0, 1, 4'hF, 1, 1, 0);
    add(1, 0, 0, 0, 6, 4'hE, 1, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 2, 1, 0);
    add(1, 0, 0, 0, 6, 4'hD, 2, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 3, 1, 0);
    add(1, 0, 0, 0, 1, 4'hB, 3, 0, 0);
    add(1, 1, 1, 31, 1, 4'hB, 3, 0, 0);
    add(1, 0, 0, 0, 4, 4'hB, 3, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 4, 1, 0);
    add(1, 0, 0, 0, 6, 4'h7, 4, 0, 0);
    // frame 3: new value for digit 1
    add(1, 0, 0, 0, 1, 4'hF, 1, 1, 1);
    add(1, 0, 0, 0, 1, 4'hF, 1, 1, 0);
    add(1, 0, 0, 0, 6, 4'hE, 1, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 31, 1, 0);
    add(1, 0, 0, 0, 6, 4'hD, 31, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 3, 1, 0);
    add(1, 0, 0, 0, 6, 4'hB, 3, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 4, 1, 0);
    add(1, 0, 0, 0, 6, 4'h7, 4, 0, 0);
    // frame 4: write on the commit edge is merged
    add(1, 1, 0, 17, 1, 4'hF, 17, 1, 1);
    add(1, 0, 0, 0, 1, 4'hF, 17, 1, 0);
    add(1, 0, 0, 0, 6, 4'hE, 17, 0, 0);
    add(1, 1, 5, 9, 1, 4'hF, 31, 1, 0);
    add(1, 0, 0, 0, 1, 4'hF, 31, 1, 0);
    add(1, 0, 0, 0, 6, 4'hD, 31, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 3, 1, 0);
    add(1, 0, 0, 0, 6, 4'hB, 3, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 4, 1, 0);
    add(1, 0, 0, 0, 6, 4'h7, 4, 0, 0);
    // frame 5: out-of-range write left every digit alone
    add(1, 0, 0, 0, 1, 4'hF, 17, 1, 1);
    add(1, 0, 0, 0, 1, 4'hF, 17, 1, 0);
    add(1, 0, 0, 0, 6, 4'hE, 17, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 31, 1, 0);
    add(1, 0, 0, 0, 6, 4'hD, 31, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 3, 1, 0);
    add(1, 0, 0, 0, 6, 4'hB, 3, 0, 0);
    add(1, 0, 0, 0, 2, 4'hF, 4, 1, 0);
    add(1, 0, 0, 0, 6, 4'h7, 4, 0, 0);

    #2;
    check("reset_init", 4'hF, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        cycle(vecs[i].e, vecs[i].w, vecs[i].a, vecs[i].d);
        check($sformatf("vec%0d.%0d", i, r), vecs[i].x_an, vecs[i].x_code, vecs[i].x_bl, vecs[i].x_fd);
      end
    end

    // enable drop at cnt=3 of digit 1 lit time
    repeat (14) cycle(1, 0, 0, 0);
    check("drop_pre", 4'hD, 31, 1'b0, 1'b0);
    cycle(0, 0, 0, 0);
    check("drop_idle", 4'hF, 0, 1'b1, 1'b0);
    cycle(1, 0, 0, 0);
    check("restart_b0", 4'hF, 17, 1'b1, 1'b0);
    cycle(1, 0, 0, 0);
    check("restart_b1", 4'hF, 17, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, 0, 0);
      check($sformatf("restart_show%0d", k), 4'hE, 17, 1'b0, 1'b0);
    end
    for (int k = 8; k < FRAME; k++) begin
      cycle(1, 0, 0, 0);
      check_fd($sformatf("restart_nofd%0d", k), 1'b0);
    end
    cycle(1, 0, 0, 0);
    check("restart_fd", 4'hF, 17, 1'b1, 1'b1);

    // asynchronous reset during digit 2 lit time
    repeat (18) cycle(1, 0, 0, 0);
    check("rst_pre", 4'hB, 3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async", 4'hF, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold", 4'hF, 0, 1'b1, 1'b0);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    check("rst_b0", 4'hF, 0, 1'b1, 1'b0);
    cycle(1, 0, 0, 0);
    check("rst_b1", 4'hF, 0, 1'b1, 1'b0);
    cycle(1, 0, 0, 0);
    check("rst_show", 4'hE, 0, 1'b0, 1'b0);

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 7)), 5'($urandom));
      check_model($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
